jtag_scan_ctrl: RTL and testbench
=================================

Name: jtag_scan_ctrl

Overview:
JTAG master sequencer that turns scan commands into TMS/TDI bit streams and captures TDO. It sits between the test-controller command path and the JTAG pins (tdi, tms, tdo), shadowing the TAP state machine so that IR scans, DR scans, TAP resets and idle runs can be issued as single handshaked commands. One command is in flight at a time, and each completed command returns one response.

Parameters:
MAX_LEN, 32, maximum scan length in bits; width of cmd_data and rsp_data.
LEN_W, 6, width of cmd_len; must satisfy 2**LEN_W > MAX_LEN.

Ports:
tck  input  1  JTAG clock; all state updates on posedge tck.
trst  input  1  asynchronous active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  controller can accept a command.
cmd_op  input  2  00 = TAP reset, 01 = IR scan, 10 = DR scan, 11 = idle run.
cmd_len  input  LEN_W  scan length in bits, or idle-run cycle count.
cmd_data  input  MAX_LEN  TDI data, shifted out LSB first.
rsp_valid  output  1  one-cycle pulse when a command completes.
rsp_data  output  MAX_LEN  captured TDO, LSB = first bit captured.
tms  output  1  registered TMS.
tdi  output  1  registered TDI.
tdo  input  1  TDO from the TAP, sampled on posedge tck.

Behaviour:
- Reset (trst low, asynchronous): tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_data=0, state=TLR.
- After trst release:
  - First posedge: TLR presents tms=0.
  - Next posedge: state=IDLE (TAP now in Run-Test/Idle), cmd_ready=1.
- Output timing: tms/tdi change only on posedge. The TAP samples each value at the following posedge.
- Handshake:
  - Command accepted on a posedge with cmd_valid & cmd_ready.
  - cmd_ready=1 only in IDLE; it drops the cycle after acceptance.
  - cmd_len and cmd_data are latched at acceptance.
- States: TLR, IDLE, RST5, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, RUN.
- TMS stream presented, starting from the acceptance edge:
  - IR scan: 1 (SEL_DR), 1 (SEL_IR), 0 (CAPTURE), 0 (enter shift), then len shift bits with tms=0 except the last with tms=1 (EXIT1), then 1 (UPDATE), 0 (back to RTI). Total len+6 values.
  - DR scan: 1, 0, 0, then len shift bits (last with tms=1), then 1, 0. Total len+5 values.
  - TAP reset: tms=1 for 5 cycles (RST5 counter), then 0. Total 6 values. rsp_data=0.
  - Idle run: tms=0 for len cycles (RUN counter). rsp_data=0.
- TDI: during the shift phase, tdi = latched data bit i on the i-th shift value. tdi=0 at all other times.
- TDO capture:
  - Bit i is sampled on the posedge at which the TAP consumes tdi bit i, i.e. one tck after that bit was driven.
  - Captured bits fill from bit 0 upward; bits len..MAX_LEN-1 of rsp_data are 0.
- Completion:
  - After the last TMS value is consumed, the state returns to IDLE.
  - rsp_valid=1 for exactly one cycle, with cmd_ready=1 in the same cycle.
  - Acceptance-edge to rsp_valid-edge latency: IR len+6, DR len+5, reset 6, idle len.
  - rsp_data holds its value until the next completion.
- Boundary conditions:
  - len=0 for a scan or idle run: no TAP activity; rsp_valid (rsp_data=0) on the next posedge.
  - len>MAX_LEN: clamped to MAX_LEN.
  - A command accepted in the rsp_valid cycle is legal and starts immediately.
  - No response backpressure; a consumer must take rsp_data while rsp_valid is high.
  - trst asserted mid-command: abort immediately to reset values; no rsp_valid for the aborted command.
  - Bit and cycle counters are LEN_W wide and never wrap, because length is clamped.

Test Plan:
- Reset then idle: release trst -> tms=1 then 0, cmd_ready=1 on the second posedge, tdi=0 throughout.
- IR scan: len=4, data=4'b1010, TAP model returns TDO 4'b0001.
  - tms stream must be 1,1,0,0,0,0,0,1,1,0.
  - tdi during shift must be 0,1,0,1.
  - rsp_valid 10 cycles after acceptance, rsp_data=32'h1.
- DR scan: len=32, data=32'hDEADBEEF, TAP model looping TDI to TDO through a 1-bit bypass register.
  - rsp_valid after 37 cycles.
  - rsp_data = (32'hDEADBEEF<<1) | 0, truncated to 32 bits.
- TAP reset then idle run len=3: tms=1,1,1,1,1,0 then 0,0,0; two rsp_valid pulses 6 and 3 cycles after their respective acceptances.
- Boundaries: scan len=0 -> rsp_valid next cycle, tms held 0. len=40 -> behaves as len=32 (37-cycle DR).
- trst pulled low in the middle of the DR shift phase -> tms=1, cmd_ready=0, no rsp_valid. After release, the next IR scan completes correctly.

Source files
------------

// File: rtl/jtag_scan_ctrl_if.sv
// Command/response channel between the test controller and jtag_scan_ctrl.
//   cmd_valid/cmd_ready : command handshake
//   cmd_op              : 00 TAP reset, 01 IR scan, 10 DR scan, 11 idle run
//   cmd_len             : scan length in bits, or idle-run cycle count
//   cmd_data            : TDI bits, LSB shifted out first
//   rsp_valid/rsp_data  : one-cycle completion pulse with captured TDO
interface jtag_scan_ctrl_if #(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned LEN_W   = 6
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [LEN_W-1:0]   cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/jtag_scan_ctrl.sv
// JTAG master sequencer: turns handshaked scan commands into registered
// TMS/TDI streams while shadowing the TAP, and captures TDO into a response.
//   tck, trst : JTAG clock, asynchronous active-low reset
//   bus       : command/response channel (slave side)
//   tms, tdi  : registered TAP drive, change on posedge tck only
//   tdo       : TAP output, sampled on posedge tck
// Each state is named after the TAP state that the value currently on tms
// drives the TAP into at the next edge.
module jtag_scan_ctrl #(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned LEN_W   = 6
) (
  input  logic             tck,
  input  logic             trst,
  jtag_scan_ctrl_if.slave  bus,
  output logic             tms,
  output logic             tdi,
  input  logic             tdo
);

  typedef enum logic [3:0] {
    TLR, IDLE, RST5, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, RUN
  } state_e;

  localparam logic [1:0]       OP_RESET = 2'b00;
  localparam logic [1:0]       OP_IR    = 2'b01;
  localparam logic [1:0]       OP_RUN   = 2'b11;
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] RST_CYC  = LEN_W'(5);
  localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               is_ir_q, is_ir_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               ready_q, ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
  logic [LEN_W-1:0]   len_clamp;

  assign tms           = tms_q;
  assign tdi           = tdi_q;
  assign bus.cmd_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    is_ir_d     = is_ir_q;
    data_d      = data_q;
    cap_d       = cap_q;
    tms_d       = 1'b0;
    tdi_d       = 1'b0;
    ready_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    len_clamp   = (bus.cmd_len > LEN_MAX) ? LEN_MAX : bus.cmd_len;

    // This edge consumes shift bit cnt_q-1 (the final bit when leaving EXIT1).
    if ((state_q == SHIFT && cnt_q != '0) || state_q == EXIT1) begin
      cap_d = cap_q | (MAX_LEN'(tdo) << (cnt_q - ONE));
    end

    case (state_q)
      // Reset drives tms=1; the TAP reaches Run-Test/Idle once a 0 is consumed.
      TLR: begin
        if (!tms_q) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
      IDLE: begin
        ready_d = 1'b1;
        if (bus.cmd_valid && ready_q) begin
          ready_d = 1'b0;
          cap_d   = '0;
          len_d   = len_clamp;
          data_d  = bus.cmd_data;
          is_ir_d = (bus.cmd_op == OP_IR);
          cnt_d   = ONE;
          if (bus.cmd_op == OP_RESET) begin
            state_d = RST5;
            len_d   = '0;
            tms_d   = 1'b1;
          end else if (bus.cmd_op == OP_RUN || len_clamp == '0) begin
            // Zero-length scans complete through RUN without touching the TAP.
            state_d = RUN;
          end else begin
            state_d = SEL_DR;
            tms_d   = 1'b1;
          end
        end
      end
      RST5: begin
        if (cnt_q == RST_CYC) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + ONE;
          tms_d = 1'b1;
        end
      end
      SEL_DR: begin
        if (is_ir_q) begin
          state_d = SEL_IR;
          tms_d   = 1'b1;
        end else begin
          state_d = CAPTURE;
        end
      end
      SEL_IR:  state_d = CAPTURE;
      CAPTURE: begin
        state_d = SHIFT;
        cnt_d   = '0;
      end
      SHIFT: begin
        tdi_d  = data_q[0];
        data_d = data_q >> 1;
        cnt_d  = cnt_q + ONE;
        if (cnt_q == len_q - ONE) begin
          state_d = EXIT1;
          tms_d   = 1'b1;
        end
      end
      EXIT1: begin
        state_d = UPDATE;
        tms_d   = 1'b1;
      end
      UPDATE: begin
        state_d = RUN;
        cnt_d   = len_q;
      end
      RUN: begin
        if (cnt_q >= len_q) begin
          state_d     = IDLE;
          ready_d     = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_data_d  = cap_q;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = TLR;
        tms_d   = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      state_q     <= TLR;
      cnt_q       <= '0;
      len_q       <= '0;
      is_ir_q     <= 1'b0;
      data_q      <= '0;
      cap_q       <= '0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      is_ir_q     <= is_ir_d;
      data_q      <= data_d;
      cap_q       <= cap_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_jtag_scan_ctrl.sv
module tb_jtag_scan_ctrl;
  localparam int unsigned MAX_LEN = 32;
  localparam int unsigned LEN_W   = 6;

  logic tck     = 1'b0;
  logic trst    = 1'b0;
  logic byp     = 1'b0;
  logic tdo_man = 1'b0;
  logic use_byp = 1'b0;
  logic tms, tdi, tdo;

  int n_cmp = 0;
  int n_bad = 0;

  jtag_scan_ctrl_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) bus ();

  jtag_scan_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .tck  (tck),
    .trst (trst),
    .bus  (bus),
    .tms  (tms),
    .tdi  (tdi),
    .tdo  (tdo)
  );

  always #5 tck = ~tck;

  // One-bit bypass register: TDO follows TDI one tck later.
  always @(posedge tck) byp <= tdi;
  assign tdo = use_byp ? byp : tdo_man;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 20 && bus.cmd_ready !== 1'b1; k++) begin
      @(posedge tck); #1;
    end
  endtask

  // Issue one command (cmd_ready assumed high) and record the streams.
  // Index k of the vectors is the value presented k edges after acceptance;
  // tdo_seq[k] is the TDO level seen by the DUT at that same edge.
  task automatic issue(input logic [1:0] op, input logic [5:0] len,
                       input logic [31:0] data, input logic [63:0] tdo_seq,
                       output int lat, output logic [63:0] tms_v,
                       output logic [63:0] tdi_v, output logic [31:0] rdata,
                       output logic rdy_rsp, output logic rdy_acc);
    lat = -1; tms_v = '0; tdi_v = '0; rdata = '0; rdy_rsp = 1'b0; rdy_acc = 1'b1;
    bus.cmd_op = op; bus.cmd_len = len; bus.cmd_data = data; bus.cmd_valid = 1'b1;
    tdo_man = tdo_seq[0];
    for (int k = 0; k < 80 && lat < 0; k++) begin
      @(posedge tck); #1;
      if (k == 0) begin
        bus.cmd_valid = 1'b0;
        rdy_acc = bus.cmd_ready;
      end
      if (k < 64) begin
        tms_v[k] = tms;
        tdi_v[k] = tdi;
      end
      if (k < 63) tdo_man = tdo_seq[k+1];
      if (bus.rsp_valid === 1'b1) begin
        lat = k; rdata = bus.rsp_data; rdy_rsp = bus.cmd_ready;
      end
    end
  endtask

  initial begin
    int          lat;
    logic [63:0] tv, dv;
    logic [31:0] rd;
    logic        rr, ra, seen;

    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_len = '0; bus.cmd_data = '0;

    // Reset values
    #12;
    check("rst_tms", 32'(tms), 32'd1);
    check("rst_tdi", 32'(tdi), 32'd0);
    check("rst_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_rspv", 32'(bus.rsp_valid), 32'd0);
    check("rst_rspd", bus.rsp_data, 32'd0);
    @(negedge tck); trst = 1'b1;
    @(posedge tck); #1;
    check("rel1_tms", 32'(tms), 32'd0);
    check("rel1_ready", 32'(bus.cmd_ready), 32'd0);
    @(posedge tck); #1;
    check("rel2_ready", 32'(bus.cmd_ready), 32'd1);
    check("rel2_tms", 32'(tms), 32'd0);
    check("rel2_tdi", 32'(tdi), 32'd0);

    // IR scan len=4 data 1010, TDO bit0=1 (consumed 5 edges after acceptance)
    issue(2'b01, 6'd4, 32'hA, 64'h20, lat, tv, dv, rd, rr, ra);
    check("ir_lat", lat, 32'd10);
    check("ir_tms", tv[31:0], 32'h183);
    check("ir_tdi", dv[31:0], 32'h0A0);
    check("ir_rsp", rd, 32'h1);
    check("ir_rdy_rsp", 32'(rr), 32'd1);
    check("ir_rdy_acc", 32'(ra), 32'd0);

    // Zero-length DR scan: response next edge, data zero, no TAP activity
    issue(2'b10, 6'd0, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, lat, tv, dv, rd, rr, ra);
    check("len0_lat", lat, 32'd1);
    check("len0_tms", tv[31:0], 32'h0);
    check("len0_rsp", rd, 32'h0);

    // DR scan len=32 through bypass
    use_byp = 1'b1;
    issue(2'b10, 6'd32, 32'hDEAD_BEEF, 64'h0, lat, tv, dv, rd, rr, ra);
    check("dr_lat", lat, 32'd37);
    check("dr_rsp", rd, 32'hBD5B_7DDE);
    check("dr_tms_lo", tv[31:0], 32'h1);
    check("dr_tms_hi", tv[63:32], 32'hC);
    check("dr_tdi", dv[34:3], 32'hDEAD_BEEF);
    use_byp = 1'b0;

    // TAP reset, then idle run len=3 issued in the response cycle
    issue(2'b00, 6'd0, 32'h0, 64'h0, lat, tv, dv, rd, rr, ra);
    check("trs_lat", lat, 32'd6);
    check("trs_tms", tv[31:0], 32'h1F);
    check("trs_rsp", rd, 32'h0);
    issue(2'b11, 6'd3, 32'h0, 64'h0, lat, tv, dv, rd, rr, ra);
    check("run_lat", lat, 32'd3);
    check("run_tms", tv[31:0], 32'h0);
    check("run_rdy_acc", 32'(ra), 32'd0);

    // Over-length DR scan clamps to 32
    use_byp = 1'b1;
    issue(2'b10, 6'd40, 32'h1234_5678, 64'h0, lat, tv, dv, rd, rr, ra);
    check("clamp_lat", lat, 32'd37);
    check("clamp_rsp", rd, 32'h2468_ACF0);
    @(posedge tck); #1;
    check("rspv_one_cycle", 32'(bus.rsp_valid), 32'd0);
    check("rsp_hold", bus.rsp_data, 32'h2468_ACF0);
    use_byp = 1'b0;

    // trst mid DR shift
    bus.cmd_op = 2'b10; bus.cmd_len = 6'd32; bus.cmd_data = 32'hFFFF_FFFF; bus.cmd_valid = 1'b1;
    @(posedge tck); #1;
    bus.cmd_valid = 1'b0;
    repeat (15) @(posedge tck);
    #3 trst = 1'b0;
    #1;
    check("abort_tms", 32'(tms), 32'd1);
    check("abort_tdi", 32'(tdi), 32'd0);
    check("abort_ready", 32'(bus.cmd_ready), 32'd0);
    check("abort_rspv", 32'(bus.rsp_valid), 32'd0);
    seen = 1'b0;
    repeat (3) begin
      @(posedge tck); #1;
      if (bus.rsp_valid !== 1'b0) seen = 1'b1;
    end
    @(negedge tck); trst = 1'b1;
    for (int k = 0; k < 20 && bus.cmd_ready !== 1'b1; k++) begin
      @(posedge tck); #1;
      if (bus.rsp_valid !== 1'b0) seen = 1'b1;
    end
    check("abort_no_rsp", 32'(seen), 32'd0);
    wait_ready();
    check("abort_ready_back", 32'(bus.cmd_ready), 32'd1);

    // IR scan after abort: len=4 data 0101, TDO bits 1,2 high
    issue(2'b01, 6'd4, 32'h5, 64'hC0, lat, tv, dv, rd, rr, ra);
    check("ir2_lat", lat, 32'd10);
    check("ir2_tms", tv[31:0], 32'h183);
    check("ir2_tdi", dv[31:0], 32'h050);
    check("ir2_rsp", rd, 32'h6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
